spart_echo_master: RTL and testbench
====================================

// Module: spart_echo_master
// PURPOSE
//  Bus master for one SPART. Programs the baud divisor, reads received bytes into an RX FIFO of
//  depth DEPTH, and writes them back out to the SPART transmitter (byte echo). Divisor is re-sent
//  whenever br_cfg changes. Sits between the board switches and the SPART databus, replacing the
//  single-byte driver FSM.
// PARAMETERS
//  DEPTH    8    RX FIFO entries, power of two, >=2
//  DIV_W    16   divisor width; driven to the bus as low byte then high byte (bits above 15 dropped)
//  DIV_CFG0 650  divisor for br_cfg=00 (4800 baud @ 50 MHz)
//  DIV_CFG1 325  divisor for br_cfg=01 (9600)
//  DIV_CFG2 162  divisor for br_cfg=10 (19200)
//  DIV_CFG3 80   divisor for br_cfg=11 (38400)
// PORTS
//  clk          in     1         clock
//  rst          in     1         reset, asynchronous, active-high
//  br_cfg       in     2         baud select, asynchronous (switches)
//  rda          in     1         SPART: receive data available
//  tbr          in     1         SPART: transmit buffer ready
//  iocs         out    1         SPART chip select
//  iorw         out    1         1=read, 0=write
//  ioaddr       out    2         00 data, 01 status, 10 div low, 11 div high
//  databus      inout  8         shared SPART data bus
//  fifo_count   out    clog2(DEPTH+1)  bytes held
//  fifo_full    out    1         fifo_count==DEPTH
//  data_capture out    8         last byte written to SPART
// BEHAVIOUR
//  Reset: iocs=0, iorw=1, ioaddr=01, databus Z, fifo empty, data_capture=FF, div_pending=1, state IDLE.
//  br_cfg passes through a 2-flop synchroniser; synced value != last programmed cfg -> div_pending=1.
//  Bus outputs are decoded from state, one transaction per cycle, and IDLE sits between transactions.
//   IDLE:    iocs=0, ioaddr=01, iorw=1.
//   BR_LOW:  iocs=1, iorw=0, ioaddr=10, bus=div[7:0].
//   BR_HIGH: iocs=1, iorw=0, ioaddr=11, bus=div[15:8]; exit clears div_pending.
//   RX:      iocs=1, iorw=1, ioaddr=00; bus sampled on the exit edge and pushed to the FIFO.
//   TX:      iocs=1, iorw=0, ioaddr=00, bus=FIFO head; head popped and copied to data_capture on exit.
//  IDLE arbitration (priority order):
//   1. div_pending -> BR_LOW. Divisor and cfg are latched on entry, so both halves match.
//   2. rda & !fifo_full -> RX.
//   3. tbr & fifo_count!=0 -> TX.
//   4. otherwise stay in IDLE.
//  BR_LOW always goes to BR_HIGH; every other non-IDLE state returns to IDLE.
//  Latency: rda high in IDLE -> RX next cycle -> count++ after that edge. Earliest TX is 2 cycles later.
//  databus is driven only in BR_LOW, BR_HIGH and TX; Z in all other states.
//  FIFO full: rda is ignored and the SPART holds its byte, so no bytes are lost.
//   With tbr=0 and FIFO full, the block idles.
//  br_cfg change during a BR sequence: the sequence completes with the latched value,
//   then div_pending re-asserts and the new value is programmed.
//  Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Push and pop never coincide
//   (one state per cycle).
//  rst mid-transaction: returns to reset values immediately and the FIFO contents are discarded.
// CONFIGURATION
//  SPART_ECHO_STATS_EN defined: outputs rx_bytes[15:0] and tx_bytes[15:0] count RX and TX exits.
//   Both wrap at FFFF and reset to 0.
//  Not defined: both ports are still present and tied to 0; no counter flops.
// STRUCTURE
//  spart_pkg holds: state encoding, IOADDR_DATA/STATUS/DIV_LO/DIV_HI constants, IDLE bus defaults.
//  Sub-module spart_byte_fifo (DEPTH, 8-bit; push, pop, head, count, full, empty).
//  The FSM, divisor mux, synchroniser and bus tristate stay in the top module.
// TESTING
//  1. Reset, br_cfg=01 -> BR_LOW drives 8'h45 on 10, BR_HIGH drives 8'h01 on 11, then IDLE with bus Z.
//  2. rda pulse with bus=8'hA5, tbr=1 -> RX, IDLE, TX drives A5 on 00 with iorw=0;
//     data_capture=A5, count back to 0.
//  3. tbr=0, feed DEPTH+2 bytes via rda -> fifo_full=1 after DEPTH bytes, no RX while full;
//     tbr=1 -> drains in order.
//  4. br_cfg 01->11 mid-stream -> within 3 cycles of the synced change: 8'h50 then 8'h00.
//     Queued bytes are preserved.
//  5. rst asserted during TX -> bus Z, iocs=0 and count=0 that cycle; then re-programs the divisor.
//  6. STATS_EN build: echo 300 bytes -> rx_bytes=tx_bytes=300. Undefined build: both read 0.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared state encoding and SPART bus constants for spart_echo_master.
package spart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BR_LOW,
    ST_BR_HIGH,
    ST_RX,
    ST_TX
  } state_e;

  localparam logic [1:0] IOADDR_DATA   = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DIV_LO = 2'b10;
  localparam logic [1:0] IOADDR_DIV_HI = 2'b11;

  localparam logic       IDLE_IOCS   = 1'b0;
  localparam logic       IDLE_IORW   = 1'b1;
  localparam logic [1:0] IDLE_IOADDR = IOADDR_STATUS;

endpackage

// File: rtl/spart_echo_master_if.sv
// SPART control/handshake signals; databus stays a top-level inout.
interface spart_echo_master_if;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  modport master (input rda, input tbr, output iocs, output iorw, output ioaddr);
  modport slave  (output rda, output tbr, input iocs, input iorw, input ioaddr);
endinterface

// File: rtl/spart_byte_fifo.sv
// Byte FIFO, DEPTH entries (power of two); pointers wrap modulo DEPTH.
module spart_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push && !full) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      count_d         = count_q + CW'(1);
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spart_echo_master.sv
// SPART bus master: programs the baud divisor, echoes received bytes through a FIFO.
// Optional SPART_ECHO_STATS_EN adds rx_bytes/tx_bytes counters (tied to 0 otherwise).
module spart_echo_master
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DIV_CFG0 = 650,
  parameter int unsigned DIV_CFG1 = 325,
  parameter int unsigned DIV_CFG2 = 162,
  parameter int unsigned DIV_CFG3 = 80,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           br_cfg,
  spart_echo_master_if.master  bus,
  inout  wire  [7:0]           databus,
  output logic [CW-1:0]        fifo_count,
  output logic                 fifo_full,
  output logic [7:0]           data_capture,
  output logic [15:0]          rx_bytes,
  output logic [15:0]          tx_bytes
);

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       cfg_q, cfg_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_sel;
  logic [15:0]      div_bus;
  logic             div_pending_q, div_pending_d;
  logic [7:0]       data_capture_q, data_capture_d;

  logic             drive_en;
  logic [7:0]       drive_data;
  logic             fifo_push, fifo_pop, fifo_empty;
  logic [7:0]       fifo_head;

  spart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (databus),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    div_sel = '0;
    unique case (sync2_q)
      2'b00:   div_sel = DIV_W'(DIV_CFG0);
      2'b01:   div_sel = DIV_W'(DIV_CFG1);
      2'b10:   div_sel = DIV_W'(DIV_CFG2);
      default: div_sel = DIV_W'(DIV_CFG3);
    endcase
  end

  assign div_bus      = 16'(div_q);
  assign fifo_push    = (state_q == ST_RX);
  assign fifo_pop     = (state_q == ST_TX);
  assign data_capture = data_capture_q;
  assign databus      = drive_en ? drive_data : 'z;

  always_comb begin
    state_d        = state_q;
    cfg_d          = cfg_q;
    div_d          = div_q;
    div_pending_d  = div_pending_q;
    data_capture_d = data_capture_q;
    unique case (state_q)
      ST_IDLE: begin
        if (div_pending_q) begin
          // Latch both cfg and divisor so the two halves always come from one value.
          state_d = ST_BR_LOW;
          cfg_d   = sync2_q;
          div_d   = div_sel;
        end else if (bus.rda && !fifo_full) begin
          state_d = ST_RX;
        end else if (bus.tbr && !fifo_empty) begin
          state_d = ST_TX;
        end
      end
      ST_BR_LOW:  state_d = ST_BR_HIGH;
      ST_BR_HIGH: begin
        state_d       = ST_IDLE;
        div_pending_d = 1'b0;
      end
      ST_RX:      state_d = ST_IDLE;
      ST_TX: begin
        state_d        = ST_IDLE;
        data_capture_d = fifo_head;
      end
      default:    state_d = ST_IDLE;
    endcase
    // A change seen during a BR sequence overrides the clear and forces a re-program.
    if (sync2_q != cfg_q) div_pending_d = 1'b1;
  end

  always_comb begin
    bus.iocs   = IDLE_IOCS;
    bus.iorw   = IDLE_IORW;
    bus.ioaddr = IDLE_IOADDR;
    drive_en   = 1'b0;
    drive_data = '0;
    unique case (state_q)
      ST_BR_LOW: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = IOADDR_DIV_LO;
        drive_en   = 1'b1;
        drive_data = div_bus[7:0];
      end
      ST_BR_HIGH: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = IOADDR_DIV_HI;
        drive_en   = 1'b1;
        drive_data = div_bus[15:8];
      end
      ST_RX: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b1;
        bus.ioaddr = IOADDR_DATA;
      end
      ST_TX: begin
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b0;
        bus.ioaddr = IOADDR_DATA;
        drive_en   = 1'b1;
        drive_data = fifo_head;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sync1_q        <= '0;
      sync2_q        <= '0;
      cfg_q          <= '0;
      div_q          <= '0;
      div_pending_q  <= 1'b1;
      data_capture_q <= '1;
    end else begin
      state_q        <= state_d;
      sync1_q        <= br_cfg;
      sync2_q        <= sync1_q;
      cfg_q          <= cfg_d;
      div_q          <= div_d;
      div_pending_q  <= div_pending_d;
      data_capture_q <= data_capture_d;
    end
  end

`ifdef SPART_ECHO_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    if (state_q == ST_RX) rx_cnt_d = rx_cnt_q + 16'd1;
    if (state_q == ST_TX) tx_cnt_d = tx_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign rx_bytes = rx_cnt_q;
  assign tx_bytes = tx_cnt_q;
`else
  assign rx_bytes = '0;
  assign tx_bytes = '0;
`endif

endmodule

// File: tb/tb_spart_echo_master.sv
// Directed bench for spart_echo_master with a small SPART bus model (pulled-up databus).
module tb_spart_echo_master;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    br_cfg;
  logic          tbr;
  logic          rda_m;
  logic          tb_en;
  logic [7:0]    tb_drv;
  wire  [7:0]    databus;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic [7:0]    data_capture;
  logic [15:0]   rx_bytes;
  logic [15:0]   tx_bytes;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       pop_pending = 1'b0;
  int         rx_seen = 0;
  int         tx_seen = 0;

  spart_echo_master_if bus_if ();

  assign bus_if.rda = rda_m;
  assign bus_if.tbr = tbr;
  assign databus    = (tb_en && bus_if.iorw) ? tb_drv : 'z;
  pullup pu_bus (databus);

  spart_echo_master #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .br_cfg       (br_cfg),
    .bus          (bus_if),
    .databus      (databus),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .data_capture (data_capture),
    .rx_bytes     (rx_bytes),
    .tx_bytes     (tx_bytes)
  );

  always #5 clk = ~clk;

  function automatic logic is_idle();
    return !bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'b01;
  endfunction
  function automatic logic is_rx();
    return bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'b00;
  endfunction
  function automatic logic is_tx();
    return bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'b00;
  endfunction
  function automatic logic is_brlo();
    return bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'b10;
  endfunction
  function automatic logic is_brhi();
    return bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'b11;
  endfunction

  // SPART model: offers queued bytes via rda, consumes one after each RX read, records TX writes.
  always @(negedge clk) begin
    if (rst) begin
      pop_pending = 1'b0;
    end else begin
      if (pop_pending) begin
        rx_q.delete(0);
        pop_pending = 1'b0;
      end
      if (is_rx()) begin
        pop_pending = 1'b1;
        rx_seen++;
      end
      if (is_tx()) begin
        tx_q.push_back(databus);
        tx_seen++;
      end
    end
    rda_m  = (rx_q.size() != 0);
    tb_en  = (rx_q.size() != 0);
    tb_drv = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_br(input string nm, input logic [7:0] lo, input logic [7:0] hi);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      if (is_brlo() && databus == lo) found = 1'b1;
    end
    check({nm, " br_low seen"}, 32'(found), 32'd1);
    if (found) begin
      step();
      check({nm, " br_high addr"}, 32'(is_brhi()), 32'd1);
      check({nm, " br_high data"}, 32'(databus), 32'(hi));
      step();
      check({nm, " idle after br"}, 32'(is_idle()), 32'd1);
      check({nm, " bus released"}, 32'(databus), 32'hFF);
    end
  endtask

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } div_vec_t;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_cap;
  } echo_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    div_vec_t  div_tab[3];
    echo_vec_t echo_tab[4];
    logic      found;
    int        base, bad;

    div_tab[0] = '{cfg: 2'b10, lo: 8'hA2, hi: 8'h00};
    div_tab[1] = '{cfg: 2'b00, lo: 8'h8A, hi: 8'h02};
    div_tab[2] = '{cfg: 2'b01, lo: 8'h45, hi: 8'h01};
    echo_tab[0] = '{din: 8'hA5, exp_cap: 8'hA5};
    echo_tab[1] = '{din: 8'h5A, exp_cap: 8'h5A};
    echo_tab[2] = '{din: 8'h00, exp_cap: 8'h00};
    echo_tab[3] = '{din: 8'hC3, exp_cap: 8'hC3};

    // Reset state
    rst = 1'b1; br_cfg = 2'b01; tbr = 1'b0;
    repeat (3) step();
    check("rst iocs", 32'(bus_if.iocs), 32'd0);
    check("rst iorw", 32'(bus_if.iorw), 32'd1);
    check("rst ioaddr", 32'(bus_if.ioaddr), 32'd1);
    check("rst bus z", 32'(databus), 32'hFF);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst full", 32'(fifo_full), 32'd0);
    check("rst capture", 32'(data_capture), 32'hFF);
    check("rst rx_bytes", 32'(rx_bytes), 32'd0);
    rst = 1'b0;
    wait_br("cfg01 initial", 8'h45, 8'h01);

    // Single-byte echo with latency checks
    tbr = 1'b1;
    foreach (echo_tab[k]) begin
      tx_q.delete();
      rx_q.push_back(echo_tab[k].din);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        step();
        if (is_rx()) found = 1'b1;
      end
      check("echo rx seen", 32'(found), 32'd1);
      step();
      check("echo count after rx", 32'(fifo_count), 32'd1);
      check("echo idle between", 32'(is_idle()), 32'd1);
      step();
      check("echo tx state", 32'(is_tx()), 32'd1);
      check("echo tx data", 32'(databus), 32'(echo_tab[k].din));
      step();
      check("echo capture", 32'(data_capture), 32'(echo_tab[k].exp_cap));
      check("echo count drained", 32'(fifo_count), 32'd0);
    end

    // Fill past full with tbr=0, then drain in order
    tbr = 1'b0;
    tx_q.delete();
    for (int i = 0; i < DEPTH + 2; i++) rx_q.push_back(8'(8'h10 + i));
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (fifo_full) found = 1'b1;
    end
    check("full reached", 32'(found), 32'd1);
    check("full count", 32'(fifo_count), 32'(DEPTH));
    base = rx_seen;
    repeat (10) step();
    check("no rx while full", 32'(rx_seen - base), 32'd0);
    check("spart holds bytes", 32'(rx_q.size()), 32'd2);
    check("full count held", 32'(fifo_count), 32'(DEPTH));
    tbr = 1'b1;
    for (int i = 0; i < 200 && !(tx_q.size() == DEPTH + 2 && fifo_count == 0); i++) step();
    check("drain size", 32'(tx_q.size()), 32'(DEPTH + 2));
    bad = 0;
    for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] !== 8'(8'h10 + i)) bad++;
    check("drain order", 32'(bad), 32'd0);
    check("drain full clr", 32'(fifo_full), 32'd0);

    // Baud change mid-stream keeps queued bytes
    tbr = 1'b0;
    tx_q.delete();
    for (int i = 0; i < 3; i++) rx_q.push_back(8'(8'hB0 + i));
    for (int i = 0; i < 50 && fifo_count != 3; i++) step();
    check("queued before cfg", 32'(fifo_count), 32'd3);
    br_cfg = 2'b11;
    wait_br("cfg11 midstream", 8'h50, 8'h00);
    check("queued after cfg", 32'(fifo_count), 32'd3);
    tbr = 1'b1;
    for (int i = 0; i < 50 && tx_q.size() != 3; i++) step();
    check("midstream tx size", 32'(tx_q.size()), 32'd3);
    bad = 0;
    for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] !== 8'(8'hB0 + i)) bad++;
    check("midstream order", 32'(bad), 32'd0);

    // Divisor table across the remaining configs
    tbr = 1'b0;
    foreach (div_tab[k]) begin
      br_cfg = div_tab[k].cfg;
      wait_br($sformatf("table cfg%0d", div_tab[k].cfg), div_tab[k].lo, div_tab[k].hi);
    end

    // Reset asserted during TX
    tx_q.delete();
    rx_q.push_back(8'hC0);
    rx_q.push_back(8'hC1);
    for (int i = 0; i < 50 && fifo_count != 2; i++) step();
    tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (is_tx()) found = 1'b1;
    end
    check("tx before rst", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("mid rst iocs", 32'(bus_if.iocs), 32'd0);
    check("mid rst bus z", 32'(databus), 32'hFF);
    check("mid rst count", 32'(fifo_count), 32'd0);
    check("mid rst capture", 32'(data_capture), 32'hFF);
    step();
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    rx_seen = 0;
    tx_seen = 0;
    wait_br("reprogram after rst", 8'h45, 8'h01);
    check("count after rst", 32'(fifo_count), 32'd0);

    // Long echo run and statistics
    tbr = 1'b1;
    for (int i = 0; i < 300; i++) rx_q.push_back(8'(i) ^ 8'h5A);
    for (int i = 0; i < 4000 && tx_q.size() != 300; i++) step();
    check("echo300 size", 32'(tx_q.size()), 32'd300);
    bad = 0;
    for (int i = 0; i < tx_q.size(); i++) if (tx_q[i] !== (8'(i) ^ 8'h5A)) bad++;
    check("echo300 order", 32'(bad), 32'd0);
    step();
`ifdef SPART_ECHO_STATS_EN
    check("stats rx_bytes", 32'(rx_bytes), 32'd300);
    check("stats tx_bytes", 32'(tx_bytes), 32'd300);
`else
    check("stats rx_bytes tied", 32'(rx_bytes), 32'd0);
    check("stats tx_bytes tied", 32'(tx_bytes), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
